// File: rtl/mux_n_1_pipelined_pkg.sv
// Shared helpers for parametrised selection stages: ceil-log2 and the
// select-width rule (never narrower than one bit).
package mux_n_1_pipelined_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int sel_width(input int num_inputs);
    return (clog2(num_inputs) < 1) ? 1 : clog2(num_inputs);
  endfunction

endpackage

// File: rtl/mux_n_1_pipelined_pipe_skid_reg.sv
// Generic two-entry valid/ready register slice: output register plus one skid
// entry. in_ready depends only on local state, never on out_ready.
module pipe_skid_reg #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             acc;
  logic             cons;

  assign in_ready  = !skid_valid && !rst;
  assign acc       = in_valid && in_ready;
  assign cons      = out_valid_q && out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      skid_data   <= '0;
      skid_valid  <= 1'b0;
    end else if (!out_valid_q || cons) begin
      // Output register frees up: skid entry has priority to keep order.
      if (skid_valid) begin
        out_data_q  <= skid_data;
        out_valid_q <= 1'b1;
        skid_valid  <= acc;
        if (acc) skid_data <= in_data;
      end else if (acc) begin
        out_data_q  <= in_data;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (acc) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mux_n_1_pipelined.sv
// N:1 registered selection stage; out-of-range selects yield DEFAULT_VALUE
// with an error flag that travels alongside the data through the slice.
module mux_n_1_pipelined
  import mux_n_1_pipelined_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               NUM_INPUTS    = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
  localparam int              SEL_WIDTH     = sel_width(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_lines,
  input  logic [SEL_WIDTH-1:0]        select,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_line,
  output logic                        out_sel_err,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH:0]   slice_out;

  always_comb begin
    sel_data = DEFAULT_VALUE;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (32'(select) == k) begin
        sel_data = in_lines[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  pipe_skid_reg #(
    .WIDTH(WIDTH + 1)
  ) u_slice (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({sel_err, sel_data}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (slice_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_sel_err = slice_out[WIDTH];
  assign out_line    = slice_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux_n_1_pipelined.sv
// Bench for mux_n_1_pipelined: directed cases on two instances plus a
// randomized valid/ready run on a third, checked against a queue model.
module tb_mux_n_1_pipelined;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a: W=32, N=4, default 0
  logic [127:0] a_lines;
  logic [1:0]   a_sel;
  logic         a_iv, a_ir, a_ov, a_ordy, a_err;
  logic [31:0]  a_out;
  // Instance b: W=32, N=3, default DEADBEEF
  logic [95:0]  b_lines;
  logic [1:0]   b_sel;
  logic         b_iv, b_ir, b_ov, b_ordy, b_err;
  logic [31:0]  b_out;
  // Instance c: W=7, N=5, default 55
  logic [34:0]  c_lines;
  logic [2:0]   c_sel;
  logic         c_iv, c_ir, c_ov, c_ordy, c_err;
  logic [6:0]   c_out;

  mux_n_1_pipelined #(.WIDTH(32), .NUM_INPUTS(4), .DEFAULT_VALUE(32'h0)) dut_a (
    .clk(clk), .rst(rst), .in_lines(a_lines), .select(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out_line(a_out), .out_sel_err(a_err), .out_valid(a_ov),
    .out_ready(a_ordy));

  mux_n_1_pipelined #(.WIDTH(32), .NUM_INPUTS(3), .DEFAULT_VALUE(32'hDEADBEEF)) dut_b (
    .clk(clk), .rst(rst), .in_lines(b_lines), .select(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out_line(b_out), .out_sel_err(b_err), .out_valid(b_ov),
    .out_ready(b_ordy));

  mux_n_1_pipelined #(.WIDTH(7), .NUM_INPUTS(5), .DEFAULT_VALUE(7'h55)) dut_c (
    .clk(clk), .rst(rst), .in_lines(c_lines), .select(c_sel), .in_valid(c_iv),
    .in_ready(c_ir), .out_line(c_out), .out_sel_err(c_err), .out_valid(c_ov),
    .out_ready(c_ordy));

  localparam logic [31:0] A0 = 32'hA0A0_0000;
  localparam logic [31:0] A1 = 32'hA1A1_0001;
  localparam logic [31:0] A2 = 32'hA2A2_0002;
  localparam logic [31:0] A3 = 32'hA3A3_0003;
  localparam logic [31:0] B2 = 32'hB2B2_2222;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for instance c: {err, data} from the selection rule.
  function automatic logic [7:0] ref_beat(input logic [34:0] lines, input logic [2:0] sel);
    logic [34:0] shifted;
    if (int'(sel) < 5) begin
      shifted = lines >> (7 * int'(sel));
      return {1'b0, shifted[6:0]};
    end
    return {1'b1, 7'h55};
  endfunction

  // Model of instance c: a FIFO of at most two beats. Checked every cycle
  // against pre-edge DUT outputs, then advanced by that edge's handshakes.
  logic [7:0] q[$];
  bit model_on = 1'b0;
  int n_popped = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (model_on) begin
        chk("c_out_valid", 64'(c_ov), 64'(q.size() > 0));
        chk("c_in_ready", 64'(c_ir), 64'((q.size() < 2) && !rst));
        if (q.size() > 0) begin
          chk("c_out_beat", 64'({c_err, c_out}), 64'(q[0]));
          if (c_ordy) begin
            void'(q.pop_front());
            n_popped++;
          end
        end
        if (!rst && c_iv && (q.size() < 2 || (c_ordy && q.size() == 2)) && c_ir)
          q.push_back(ref_beat(c_lines, c_sel));
      end
      if (rst) begin
        q.delete();
        model_on = 1'b1;
      end
    end
  end

  initial begin
    int n_acc;
    int cyc;
    bit was_acc;
    a_lines = {A3, A2, A1, A0}; a_sel = 2'd0; a_iv = 1'b1; a_ordy = 1'b1;
    b_lines = {B2, 32'hB1B1_1111, 32'hB0B0_0000}; b_sel = 2'd0; b_iv = 1'b0; b_ordy = 1'b1;
    c_lines = '0; c_sel = '0; c_iv = 1'b0; c_ordy = 1'b1;

    // Reset held two cycles with in_valid asserted
    rst = 1'b1;
    step(); step();
    chk("rst_in_ready", 64'(a_ir), 64'(0));
    chk("rst_out_valid", 64'(a_ov), 64'(0));
    chk("rst_out_line", 64'(a_out), 64'(0));
    a_iv = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(a_ir), 64'(1));
    step();

    // Streaming, one beat per cycle
    a_ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_iv = 1'b1; a_sel = 2'(k);
      step();
      chk("stream_valid", 64'(a_ov), 64'(1));
      chk("stream_line", 64'(a_out), 64'(a_lines[k*32 +: 32]));
    end
    a_iv = 1'b0;
    step();
    chk("stream_drained", 64'(a_ov), 64'(0));

    // Back-pressure into the skid entry
    a_iv = 1'b1; a_sel = 2'd0;
    step();
    chk("bp_first", 64'(a_out), 64'(A0));
    a_ordy = 1'b0; a_sel = 2'd1;
    step();
    chk("bp_skid_full", 64'(a_ir), 64'(0));
    chk("bp_hold_a0", 64'(a_out), 64'(A0));
    a_sel = 2'd2;
    step();
    chk("bp_still_a0", 64'(a_out), 64'(A0));
    a_ordy = 1'b1;
    step();
    chk("bp_then_a1", 64'(a_out), 64'(A1));
    chk("bp_ready_back", 64'(a_ir), 64'(1));
    step();
    chk("bp_then_a2", 64'(a_out), 64'(A2));
    a_iv = 1'b0;
    step();
    chk("bp_drained", 64'(a_ov), 64'(0));

    // Out-of-range select on the three-input instance
    b_iv = 1'b1; b_sel = 2'd3;
    step();
    chk("oor_line", 64'(b_out), 64'(32'hDEADBEEF));
    chk("oor_err", 64'(b_err), 64'(1));
    b_sel = 2'd2;
    step();
    chk("inrange_line", 64'(b_out), 64'(B2));
    chk("inrange_err", 64'(b_err), 64'(0));
    b_iv = 1'b0;
    step();

    // Reset with output and skid both full
    a_ordy = 1'b0; a_iv = 1'b1; a_sel = 2'd3;
    step();
    a_sel = 2'd1;
    step();
    chk("mid_skid_full", 64'(a_ir), 64'(0));
    a_iv = 1'b0; rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(a_ov), 64'(0));
    rst = 1'b0; a_ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_ghost", 64'(a_ov), 64'(0));
    end

    // Randomized valid/ready run on instance c
    n_acc = 0; cyc = 0; was_acc = 1'b0;
    while (n_acc < 10000 && cyc < 60000) begin
      if (!c_iv || was_acc) begin
        c_iv    = ($urandom_range(0, 3) != 0);
        c_sel   = 3'($urandom_range(0, 7));
        c_lines = 35'({$urandom, $urandom});
      end
      c_ordy = ($urandom_range(0, 3) != 0);
      was_acc = c_iv && c_ir;
      step();
      if (was_acc) n_acc++;
      cyc++;
    end
    if (n_acc < 10000) chk("random_timeout", 64'(n_acc), 64'(10000));
    c_iv = 1'b0; c_ordy = 1'b1;
    step(); step(); step();
    chk("random_drained", 64'(c_ov), 64'(0));
    chk("random_count", 64'(n_popped), 64'(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
